// File: rtl/fft_pkg.sv
// Shared FFT front-end types: frame geometry defaults and sample/frame typedefs.
// Also used by FFT_step1 and ButterflyUnit, so the defaults here set the system geometry.
package fft_pkg;

   localparam int DEF_SAMPLES = 8;
   localparam int DEF_WIDTH   = 3;
   localparam int IDX_W       = $clog2(DEF_SAMPLES);

   typedef logic [DEF_WIDTH-1:0]     sample_t;
   typedef sample_t [DEF_SAMPLES-1:0] frame_t;

endpackage

// File: rtl/fft_sample_framer_if.sv
// Streaming-in / frame-out bus of the sample framer.
// The slave side is the framer; the master side drives samples and consumes frames.
interface fft_sample_framer_if
   import fft_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES,
   parameter int WIDTH   = DEF_WIDTH
);
   logic [WIDTH-1:0]              in_sample;
   logic                          in_valid;
   logic                          in_sof;
   logic                          in_ready;
   logic [SAMPLES-1:0][WIDTH-1:0] sampleInputs;
   logic                          frame_valid;
   logic                          frame_ready;
   logic                          sof_error;
   logic [15:0]                   frame_count;

   modport master (
      output in_sample, in_valid, in_sof, frame_ready,
      input  in_ready, sampleInputs, frame_valid, sof_error, frame_count
   );

   modport slave (
      input  in_sample, in_valid, in_sof, frame_ready,
      output in_ready, sampleInputs, frame_valid, sof_error, frame_count
   );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame buffer: indexed write port, full flag with set/clear, whole-frame parallel read.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES,
   parameter int WIDTH   = DEF_WIDTH,
   localparam int IW     = $clog2(SAMPLES)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          wr_en_i,
   input  logic [IW-1:0]                 wr_idx_i,
   input  logic [WIDTH-1:0]              wr_data_i,
   input  logic                          set_full_i,
   input  logic                          clr_full_i,
   output logic                          full_o,
   output logic [SAMPLES-1:0][WIDTH-1:0] data_o
);

   logic [SAMPLES-1:0][WIDTH-1:0] data_q, data_d;
   logic                          full_q, full_d;

   // Next-state: write one slot, set full on completion, clear on release.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (wr_en_i) data_d[wr_idx_i] = wr_data_i;
      if (set_full_i)      full_d = 1'b1;
      else if (clr_full_i) full_d = 1'b0;
   end

   // Storage and flag registers; reset empties the bank and zeroes its contents.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/fft_sample_framer.sv
// Ping-pong sample framer: serial samples fill one bank while the other is held for the consumer.
// Holds the write/read bank pointers, write index, handshakes, resync error and frame counter.
module fft_sample_framer
   import fft_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES,
   parameter int WIDTH   = DEF_WIDTH,
   localparam int IW     = $clog2(SAMPLES)
) (
   input  logic               clk,
   input  logic               reset_n,
   fft_sample_framer_if.slave bus
);

   logic [1:0]                          bank_full;
   logic [1:0][SAMPLES-1:0][WIDTH-1:0]  bank_data;
   logic [1:0]                          bank_wr, bank_set, bank_clr;

   logic [IW-1:0] wr_idx_q, wr_idx_d, eff_idx;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic          sof_err_q, sof_err_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          accept, complete, release_frm;

   assign bus.in_ready     = reset_n && !bank_full[wr_bank_q];
   assign accept           = bus.in_valid && bus.in_ready;
   // A start-of-frame always lands at slot 0, discarding whatever partial frame was in progress.
   assign eff_idx          = bus.in_sof ? '0 : wr_idx_q;
   assign complete         = accept && (eff_idx == IW'(SAMPLES-1));
   assign bus.frame_valid  = bank_full[rd_bank_q];
   assign release_frm      = bus.frame_valid && bus.frame_ready;
   assign bus.sampleInputs = bank_data[rd_bank_q];
   assign bus.sof_error    = sof_err_q;
   assign bus.frame_count  = cnt_q;

   // Per-bank write, fill-complete and release strobes.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_wr[b]  = accept      && (wr_bank_q == 1'(b));
         bank_set[b] = complete    && (wr_bank_q == 1'(b));
         bank_clr[b] = release_frm && (rd_bank_q == 1'(b));
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank (
         .clk        (clk),
         .reset_n    (reset_n),
         .wr_en_i    (bank_wr[b]),
         .wr_idx_i   (eff_idx),
         .wr_data_i  (bus.in_sample),
         .set_full_i (bank_set[b]),
         .clr_full_i (bank_clr[b]),
         .full_o     (bank_full[b]),
         .data_o     (bank_data[b])
      );
   end

   // Pointer, resync-error and counter next-state; fill and release may both happen in one cycle.
   always_comb begin
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      sof_err_d = sof_err_q;
      cnt_d     = cnt_q;
      if (accept) begin
         wr_idx_d = eff_idx + 1'b1;   // wraps to 0 after the last slot
         if (bus.in_sof && (wr_idx_q != '0)) sof_err_d = 1'b1;
      end
      if (complete) wr_bank_d = ~wr_bank_q;
      if (release_frm) begin
         rd_bank_d = ~rd_bank_q;
         cnt_d     = cnt_q + 16'd1;
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         sof_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         sof_err_q <= sof_err_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fft_sample_framer.sv
// Bench for fft_sample_framer: frame-level queue model plus directed literal checks.
module tb_fft_sample_framer;
   localparam int S = 8;
   localparam int W = 3;
   typedef logic [S*W-1:0] fr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fft_sample_framer_if #(.SAMPLES(S), .WIDTH(W)) bus ();
   fft_sample_framer #(.SAMPLES(S), .WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: completed-but-undelivered frames in a queue, partial frame as a sample list.
   fr_t              exp_q[$];
   logic [W-1:0]     part[$];
   int               m_cnt = 0;
   bit               m_sof = 0;
   bit               started = 0;

   always @(posedge clk) begin
      bit   rel, acc;
      fr_t  f;
      started = 1;
      if (!reset_n) begin
         exp_q.delete();
         part.delete();
         m_cnt = 0;
         m_sof = 0;
      end else begin
         rel = (exp_q.size() > 0) && bus.frame_ready;
         acc = bus.in_valid && (exp_q.size() < 2);
         if (rel) begin
            void'(exp_q.pop_front());
            m_cnt++;
         end
         if (acc) begin
            if (bus.in_sof) begin
               if (part.size() != 0) m_sof = 1;
               part.delete();
            end
            part.push_back(bus.in_sample);
            if (part.size() == S) begin
               for (int k = 0; k < S; k++) f[k*W +: W] = part[k];
               exp_q.push_back(f);
               part.delete();
            end
         end
      end
   end

   // Compare DUT against model every cycle, mid-cycle.
   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 64'(bus.in_ready), 64'(reset_n && (exp_q.size() < 2)));
         chk("frame_valid", 64'(bus.frame_valid), 64'(exp_q.size() > 0));
         if (exp_q.size() > 0) chk("frame_data", 64'(bus.sampleInputs), 64'(exp_q[0]));
         chk("frame_count", 64'(bus.frame_count), 64'(m_cnt[15:0]));
         chk("sof_error", 64'(bus.sof_error), 64'(m_sof));
      end
   end

   task automatic send(input logic [W-1:0] v, input bit sof);
      int n;
      bus.in_sample = v;
      bus.in_sof    = sof;
      bus.in_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=0 required 1 at %0t", $time);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   bit done;

   initial begin
      bus.in_sample = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.frame_ready = 1'b0;
      reset_n = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
      chk("rst_data", 64'(bus.sampleInputs), 64'd0);
      chk("rst_count", 64'(bus.frame_count), 64'd0);
      chk("rst_sof_error", 64'(bus.sof_error), 64'd0);
      cyc(1);
      reset_n = 1'b1;
      bus.frame_ready = 1'b1;

      // 1: single frame 0..7, valid the cycle after the last sample
      for (int i = 0; i < S; i++) send(3'(i), i == 0);
      @(negedge clk);
      chk("t1_valid", 64'(bus.frame_valid), 64'd1);
      chk("t1_data", 64'(bus.sampleInputs), 64'(24'o76543210));
      cyc(1);
      @(negedge clk);
      chk("t1_count", 64'(bus.frame_count), 64'd1);
      cyc(1);

      // 2: consumer stalled, 24 samples -> backpressure after 16, then drain
      bus.frame_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) send(3'(i % 8), (i % 8) == 0);
         end
         begin
            cyc(40);
            @(negedge clk);
            chk("t2_backpressure", 64'(bus.in_ready), 64'd0);
            chk("t2_hold_valid", 64'(bus.frame_valid), 64'd1);
            chk("t2_hold_data", 64'(bus.sampleInputs), 64'(24'o76543210));
            cyc(1);
            bus.frame_ready = 1'b1;
         end
      join
      cyc(30);
      chk("t2_count", 64'(bus.frame_count), 64'd4);

      // 3: resync mid-frame
      bus.frame_ready = 1'b0;
      send(3'd1, 1); send(3'd2, 0); send(3'd3, 0);
      send(3'd5, 1);
      for (int i = 6; i < 13; i++) send(3'(i % 8), 0);
      @(negedge clk);
      chk("t3_valid", 64'(bus.frame_valid), 64'd1);
      chk("t3_data", 64'(bus.sampleInputs), 64'(24'o43210765));
      chk("t3_sof_error", 64'(bus.sof_error), 64'd1);
      cyc(1);
      bus.frame_ready = 1'b1;
      cyc(3);
      chk("t3_count", 64'(bus.frame_count), 64'd5);

      // 4: reset after 4 samples, then a clean frame
      for (int i = 0; i < 4; i++) send(3'(i), i == 0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("t4_rst_ready", 64'(bus.in_ready), 64'd0);
      chk("t4_rst_valid", 64'(bus.frame_valid), 64'd0);
      cyc(2);
      reset_n = 1'b1;
      for (int i = 0; i < S; i++) send(3'(7 - i), i == 0);
      cyc(3);
      chk("t4_count", 64'(bus.frame_count), 64'd1);
      chk("t4_sof_error", 64'(bus.sof_error), 64'd0);

      // 6: release of A in the same cycle as B's last sample
      bus.frame_ready = 1'b0;
      for (int i = 0; i < S; i++) send(3'(i), i == 0);
      for (int i = 0; i < S - 1; i++) send(3'(7 - i), i == 0);
      bus.frame_ready = 1'b1;
      send(3'd0, 0);
      @(negedge clk);
      chk("t6_valid", 64'(bus.frame_valid), 64'd1);
      chk("t6_ready", 64'(bus.in_ready), 64'd1);
      chk("t6_data", 64'(bus.sampleInputs), 64'(24'o01234567));
      cyc(3);
      chk("t6_count", 64'(bus.frame_count), 64'd3);

      // 5: random gaps on both sides, 100 frames
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      done = 0;
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               for (int i = 0; i < S; i++) begin
                  if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(1, 3)));
                  send(3'($urandom_range(0, 7)), i == 0);
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               cyc(1);
               bus.frame_ready = ($urandom_range(0, 2) != 0);
            end
            bus.frame_ready = 1'b1;
         end
      join
      cyc(20);
      @(negedge clk);
      chk("t5_count", 64'(bus.frame_count), 64'd100);
      chk("t5_sof_error", 64'(bus.sof_error), 64'd0);
      chk("t5_drained", 64'(bus.frame_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
